comperator_axi_ip_v1_1_disparity: RTL and testbench

COMPERATOR_AXI_IP_V1_1_DISPARITY -- requirements
Module: comperator_axi_ip_v1_1_disparity

---
 rtl/comperator_axi_ip_v1_1_disparity_if.sv | 30 +++
 rtl/comperator_axi_ip_v1_1_disparity.sv | 175 +++++++++++++++++
 tb/tb_comperator_axi_ip_v1_1_disparity.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/comperator_axi_ip_v1_1_disparity_if.sv
// Bus bundle for the disparity block: candidate-sum input stream on the
// s_* side and the per-block result on the m_* side.
interface comperator_axi_ip_v1_1_disparity_if #(
    parameter int SUM_WIDTH = 16
);
    logic                 s_valid;
    logic                 s_ready;
    logic [SUM_WIDTH-1:0] s_sum;
    logic                 s_last;
    logic [15:0]          block_index;
    logic [SUM_WIDTH-1:0] thresh;
    logic                 m_valid;
    logic                 m_ready;
    logic [23:0]          m_pixel;
    logic [15:0]          m_best_idx;
    logic                 m_nomatch;
    logic                 m_err;

    // Design side: consumes candidate beats, produces results.
    modport slave (
        input  s_valid, s_sum, s_last, block_index, thresh, m_ready,
        output s_ready, m_valid, m_pixel, m_best_idx, m_nomatch, m_err
    );

    // Environment side: drives candidate beats, accepts results.
    modport master (
        output s_valid, s_sum, s_last, block_index, thresh, m_ready,
        input  s_ready, m_valid, m_pixel, m_best_idx, m_nomatch, m_err
    );
endinterface

// File: rtl/comperator_axi_ip_v1_1_disparity.sv
// Disparity selector: scans a block's candidate SAD sums, keeps the lowest
// (first index on ties), converts the winning offset into a grey pixel and
// presents it with a valid/ready handshake.
module comperator_axi_ip_v1_1_disparity #(
    parameter int FRAME_WIDTH  = 320,
    parameter int BLOCK_SIZE   = 8,
    parameter int COMPARE_STEP = 8,
    parameter int NUM_COMPARES = ((FRAME_WIDTH - BLOCK_SIZE) / COMPARE_STEP) + 1,
    parameter int SUM_WIDTH    = 16,
    parameter int COLOUR_BITS  = 4
) (
    input  logic aclk,
    input  logic aresetn,
    comperator_axi_ip_v1_1_disparity_if.slave bus
);

    localparam int NUM_COLOUR = 2 ** COLOUR_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CALC  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q;
    logic [SUM_WIDTH-1:0] best_sum_q;
    logic [15:0]          best_idx_q;
    logic [15:0]          blk_q;
    logic [SUM_WIDTH-1:0] thresh_q;
    logic                 err_q;
    logic [23:0]          pixel_q;
    logic [15:0]          out_idx_q;
    logic                 nomatch_q;
    logic                 out_err_q;

    logic                 ready;
    logic                 accept;
    logic                 in_range;
    logic                 short_last;

    // Map block position and winning candidate offset to a clamped grey level.
    function automatic logic [COLOUR_BITS-1:0] disp_colour(input logic [15:0] blk,
                                                            input logic [15:0] idx);
        logic signed [31:0] diff;
        logic signed [31:0] scaled;
        diff = $signed(32'(blk) * 32'(BLOCK_SIZE)) - $signed(32'(idx) * 32'(COMPARE_STEP));
        if (diff < 0) begin
            return '0;
        end
        scaled = (diff * NUM_COLOUR) / FRAME_WIDTH;
        if (scaled > NUM_COLOUR - 1) begin
            return '1;
        end
        return COLOUR_BITS'(scaled);
    endfunction

    // Replicate the grey level into the low bits of each colour byte.
    function automatic logic [23:0] grey_pixel(input logic [COLOUR_BITS-1:0] colour);
        logic [7:0] byte_v;
        byte_v = 8'(colour);
        return {byte_v, byte_v, byte_v};
    endfunction

    assign ready      = (state_q == IDLE) || (state_q == ACCUM);
    assign accept     = bus.s_valid && ready;
    assign in_range   = (32'(cnt_q) < NUM_COMPARES);
    // Block ended before every candidate position was seen.
    assign short_last = bus.s_last && ((32'(cnt_q) + 32'd1) < NUM_COMPARES);

    assign bus.s_ready    = ready;
    assign bus.m_valid    = (state_q == OUT);
    assign bus.m_pixel    = pixel_q;
    assign bus.m_best_idx = out_idx_q;
    assign bus.m_nomatch  = nomatch_q;
    assign bus.m_err      = out_err_q;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bus.s_last ? CALC : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && bus.s_last) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = OUT;
            end
            OUT: begin
                if (bus.m_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Candidate tracking during the scan, result capture in CALC, clean-up on leaving OUT.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q      <= '0;
            best_sum_q <= '0;
            best_idx_q <= '0;
            blk_q      <= '0;
            thresh_q   <= '0;
            err_q      <= 1'b0;
            pixel_q    <= '0;
            out_idx_q  <= '0;
            nomatch_q  <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (state_q == IDLE) begin
                            blk_q    <= bus.block_index;
                            thresh_q <= bus.thresh;
                        end
                        if (in_range) begin
                            cnt_q <= cnt_q + 16'd1;
                            if ((cnt_q == '0) || (bus.s_sum < best_sum_q)) begin
                                best_sum_q <= bus.s_sum;
                                best_idx_q <= cnt_q;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (short_last) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    out_idx_q <= best_idx_q;
                    out_err_q <= err_q;
                    if (best_sum_q > thresh_q) begin
                        nomatch_q <= 1'b1;
                        pixel_q   <= '0;
                    end else begin
                        nomatch_q <= 1'b0;
                        pixel_q   <= grey_pixel(disp_colour(blk_q, best_idx_q));
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        cnt_q <= '0;
                        err_q <= 1'b0;
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comperator_axi_ip_v1_1_disparity.sv
// Directed bench for the disparity selector.
module tb_comperator_axi_ip_v1_1_disparity;

    logic aclk;
    logic aresetn;
    int   checks;
    int   errors;
    logic [15:0] sums [0:63];

    comperator_axi_ip_v1_1_disparity_if #(.SUM_WIDTH(16)) bus ();

    comperator_axi_ip_v1_1_disparity dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < 64; i++) sums[i] = 16'(base + i);
    endtask

    // Stream n beats starting right after a rising edge, then check the CALC cycle and OUT entry.
    task automatic run_block(input string tag, input logic [15:0] blk,
                             input logic [15:0] thr, input int n);
        bus.block_index = blk;
        bus.thresh      = thr;
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_sum   = sums[i];
            bus.s_last  = (i == n - 1);
            @(posedge aclk); #1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk({tag, " calc m_valid"}, 32'(bus.m_valid), 32'd0);
        chk({tag, " calc s_ready"}, 32'(bus.s_ready), 32'd0);
        @(posedge aclk); #1;
        chk({tag, " out m_valid"}, 32'(bus.m_valid), 32'd1);
    endtask

    task automatic expect_result(input string tag, input logic [23:0] pix,
                                 input logic [15:0] idx, input logic nm, input logic err);
        chk({tag, " m_pixel"},    32'(bus.m_pixel),    32'(pix));
        chk({tag, " m_best_idx"}, 32'(bus.m_best_idx), 32'(idx));
        chk({tag, " m_nomatch"},  32'(bus.m_nomatch),  32'(nm));
        chk({tag, " m_err"},      32'(bus.m_err),      32'(err));
    endtask

    task automatic consume(input string tag);
        bus.m_ready = 1'b1;
        @(posedge aclk); #1;
        bus.m_ready = 1'b0;
        chk({tag, " idle m_valid"}, 32'(bus.m_valid), 32'd0);
        chk({tag, " idle s_ready"}, 32'(bus.s_ready), 32'd1);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        aresetn         = 1'b0;
        bus.s_valid     = 1'b0;
        bus.s_sum       = '0;
        bus.s_last      = 1'b0;
        bus.block_index = '0;
        bus.thresh      = 16'hFFFF;
        bus.m_ready     = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        chk("reset m_valid", 32'(bus.m_valid), 32'd0);
        chk("reset s_ready", 32'(bus.s_ready), 32'd1);
        expect_result("reset", 24'h0, 16'd0, 1'b0, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // blk 10, min at 5: diff 40 -> 40*16/320 = 2
        fill(1000); sums[5] = 16'd10;
        run_block("basic", 16'd10, 16'hFFFF, 40);
        expect_result("basic", 24'h020202, 16'd5, 1'b0, 1'b0);
        consume("basic");

        // blk 39, min at 0: diff 312 -> 15
        fill(1000); sums[0] = 16'd3;
        run_block("top", 16'd39, 16'hFFFF, 40);
        expect_result("top", 24'h0F0F0F, 16'd0, 1'b0, 1'b0);
        consume("top");

        // blk 100, min at 0: diff 800 -> 40, clamped to 15
        fill(1000); sums[0] = 16'd3;
        run_block("clamp", 16'd100, 16'hFFFF, 40);
        expect_result("clamp", 24'h0F0F0F, 16'd0, 1'b0, 1'b0);
        consume("clamp");

        // blk 0, min at 3: negative diff -> 0
        fill(1000); sums[3] = 16'd1;
        run_block("neg", 16'd0, 16'hFFFF, 40);
        expect_result("neg", 24'h000000, 16'd3, 1'b0, 1'b0);
        consume("neg");

        // Tie at 7 and 20 keeps 7; blk 10: diff 24 -> 1
        fill(1000); sums[7] = 16'd5; sums[20] = 16'd5;
        run_block("tie", 16'd10, 16'hFFFF, 40);
        expect_result("tie", 24'h010101, 16'd7, 1'b0, 1'b0);
        consume("tie");

        // Threshold rejects: best 200 > 100
        fill(200);
        run_block("thr", 16'd39, 16'd100, 40);
        expect_result("thr", 24'h000000, 16'd0, 1'b1, 1'b0);
        consume("thr");

        // All-ones threshold never rejects
        fill(200);
        run_block("thrdis", 16'd39, 16'hFFFF, 40);
        expect_result("thrdis", 24'h0F0F0F, 16'd0, 1'b0, 1'b0);
        consume("thrdis");

        // Short block: last on beat 30
        fill(1000); sums[5] = 16'd10;
        run_block("short", 16'd10, 16'hFFFF, 30);
        expect_result("short", 24'h020202, 16'd5, 1'b0, 1'b1);
        consume("short");

        // Long block: 45 beats, low sum at 42 must be ignored
        fill(1000); sums[5] = 16'd10; sums[42] = 16'd1;
        run_block("long", 16'd10, 16'hFFFF, 45);
        expect_result("long", 24'h020202, 16'd5, 1'b0, 1'b1);
        consume("long");

        // Error flag clears for the next good block; then hold with m_ready low
        fill(1000); sums[0] = 16'd3;
        run_block("hold", 16'd39, 16'hFFFF, 40);
        expect_result("hold", 24'h0F0F0F, 16'd0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge aclk); #1;
            chk("hold m_valid", 32'(bus.m_valid), 32'd1);
            chk("hold s_ready", 32'(bus.s_ready), 32'd0);
            chk("hold m_pixel", 32'(bus.m_pixel), 32'h0F0F0F);
        end
        consume("hold");

        // Reset pulse mid-ACCUM
        fill(1000); sums[2] = 16'd4;
        bus.block_index = 16'd20;
        for (int i = 0; i < 10; i++) begin
            bus.s_valid = 1'b1;
            bus.s_sum   = sums[i];
            bus.s_last  = 1'b0;
            @(posedge aclk); #1;
        end
        bus.s_valid = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        chk("rst m_valid", 32'(bus.m_valid), 32'd0);
        expect_result("rst", 24'h0, 16'd0, 1'b0, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) begin
            @(posedge aclk); #1;
            chk("post-rst m_valid", 32'(bus.m_valid), 32'd0);
        end

        fill(1000); sums[5] = 16'd10;
        run_block("after", 16'd10, 16'hFFFF, 40);
        expect_result("after", 24'h020202, 16'd5, 1'b0, 1'b0);
        consume("after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
